// File: rtl/icc_branch_unit.sv
// SPARC integer condition-code register and Bicc delayed-branch/annul unit.
// Latches ALU flags on cc-setting ops, evaluates Bicc and drives fetch redirect plus slot squash.
module icc_branch_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [3:0]  RESET_ICC = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              alu_valid,
  input  logic [5:0]        op3,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              v_in,
  input  logic              c_in,
  input  logic              br_valid,
  input  logic [3:0]        cond,
  input  logic              a_bit,
  input  logic [ADDR_W-1:0] br_target_in,
  input  logic              instr_valid,
  output logic [3:0]        icc,
  output logic              cin,
  output logic              br_taken,
  output logic [ADDR_W-1:0] br_target,
  output logic              annul_slot,
  output logic              in_slot
);

  typedef enum logic {IDLE = 1'b0, SLOT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [3:0]          icc_q, icc_d;
  logic                taken_q, taken_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                annul_pend_q, annul_pend_d;

  logic                cc_op, cc_wr, cond_base, cond_taken, accept;
  logic [3:0]          flags, f;

  assign flags = {n_in, z_in, v_in, c_in};

  // cc-setting arithmetic/logic opcodes (ADDcc..XNORcc family, incl. ADDXcc/SUBXcc)
  always_comb begin
    cc_op = 1'b0;
    case (op3)
      6'b010000, 6'b011000, 6'b010100, 6'b011100, 6'b010001,
      6'b010101, 6'b010010, 6'b010110, 6'b010011, 6'b010111: cc_op = 1'b1;
      default: cc_op = 1'b0;
    endcase
  end

  assign annul_slot = (state_q == SLOT) & annul_pend_q & instr_valid;
  assign cc_wr      = alu_valid & ~stall & cc_op & ~annul_slot;
  assign f          = (cc_wr & br_valid) ? flags : icc_q;

  // f = {N,Z,V,C}; cond[3] inverts the base test (never -> always)
  always_comb begin
    cond_base = 1'b0;
    case (cond[2:0])
      3'd0: cond_base = 1'b0;
      3'd1: cond_base = f[2];
      3'd2: cond_base = f[2] | (f[3] ^ f[1]);
      3'd3: cond_base = f[3] ^ f[1];
      3'd4: cond_base = f[0] | f[2];
      3'd5: cond_base = f[0];
      3'd6: cond_base = f[3];
      3'd7: cond_base = f[1];
      default: cond_base = 1'b0;
    endcase
    cond_taken = cond_base ^ cond[3];
  end

  // A branch in an annulled slot is dropped; otherwise IDLE or DCTI couple accepts it
  assign accept = br_valid & ~stall & ((state_q == IDLE) | ~annul_pend_q);

  always_comb begin
    state_d      = state_q;
    icc_d        = icc_q;
    taken_d      = taken_q;
    tgt_d        = tgt_q;
    annul_pend_d = annul_pend_q;
    if (cc_wr) icc_d = flags;
    if (!stall) begin
      taken_d = 1'b0;
      if (accept) begin
        state_d      = SLOT;
        taken_d      = cond_taken;
        tgt_d        = br_target_in;
        annul_pend_d = a_bit & (~cond_taken | (cond == 4'b1000));
      end else if ((state_q == SLOT) && instr_valid) begin
        state_d      = IDLE;
        annul_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      icc_q        <= RESET_ICC;
      taken_q      <= 1'b0;
      tgt_q        <= '0;
      annul_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      icc_q        <= icc_d;
      taken_q      <= taken_d;
      tgt_q        <= tgt_d;
      annul_pend_q <= annul_pend_d;
    end
  end

  assign icc       = icc_q;
  assign cin       = icc_q[0];
  assign br_taken  = taken_q;
  assign br_target = tgt_q;
  assign in_slot   = (state_q == SLOT);

endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed table-driven bench for icc_branch_unit: cc latching, forwarding, annul, DCTI, stall, reset.
module tb_icc_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, alu_valid, n_in, z_in, v_in, c_in, br_valid, a_bit, instr_valid;
  logic [5:0]  op3;
  logic [3:0]  cond;
  logic [31:0] br_target_in;
  logic [3:0]  icc;
  logic        cin, br_taken, annul_slot, in_slot;
  logic [31:0] br_target;

  int n_tests = 0;
  int n_fail  = 0;

  icc_branch_unit #(.ADDR_W(32), .RESET_ICC(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .alu_valid(alu_valid), .op3(op3),
    .n_in(n_in), .z_in(z_in), .v_in(v_in), .c_in(c_in),
    .br_valid(br_valid), .cond(cond), .a_bit(a_bit), .br_target_in(br_target_in),
    .instr_valid(instr_valid), .icc(icc), .cin(cin), .br_taken(br_taken),
    .br_target(br_target), .annul_slot(annul_slot), .in_slot(in_slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        alu;
    logic [5:0]  op3;
    logic [3:0]  flg;
    logic        brv;
    logic [3:0]  cond;
    logic        a;
    logic [31:0] tgt;
    logic        iv;
    logic        e_ann;
    logic [3:0]  e_icc;
    logic        e_tk;
    logic [31:0] e_tgt;
    logic        e_slot;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic st, input logic alu, input logic [5:0] o3,
                              input logic [3:0] flg, input logic brv, input logic [3:0] cd,
                              input logic a, input logic [31:0] tgt, input logic iv,
                              input logic e_ann, input logic [3:0] e_icc, input logic e_tk,
                              input logic e_slot);
    vec_t v;
    v.stall = st;  v.alu = alu; v.op3 = o3; v.flg = flg; v.brv = brv; v.cond = cd;
    v.a = a; v.tgt = tgt; v.iv = iv; v.e_ann = e_ann; v.e_icc = e_icc; v.e_tk = e_tk;
    v.e_tgt = tgt; v.e_slot = e_slot;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; alu_valid = 0; op3 = 6'b000000; {n_in, z_in, v_in, c_in} = 4'b0000;
    br_valid = 0; cond = 4'b0000; a_bit = 0; br_target_in = 32'h0; instr_valid = 0;
  endtask

  localparam logic [5:0] ADDCC  = 6'b010000;
  localparam logic [5:0] SUBCC  = 6'b010100;
  localparam logic [5:0] ADDXCC = 6'b011000;
  localparam logic [5:0] NOP    = 6'b000000;

  initial begin
    vec_t       v;
    logic [31:0] held_tgt;

    // 0: SUBcc flags Z=1 -> icc 0100; non-cc ops leave icc alone
    vq.push_back(mk(0,1,SUBCC,   4'b0100,0,4'h0,0,32'h0,   0, 0,4'b0100,0,0));
    vq.push_back(mk(0,1,6'b000100,4'b1111,0,4'h0,0,32'h0,  0, 0,4'b0100,0,0));
    vq.push_back(mk(0,1,6'b110011,4'b1111,0,4'h0,0,32'h0,  0, 0,4'b0100,0,0));
    vq.push_back(mk(0,1,ADDCC,   4'b0000,0,4'h0,0,32'h0,   0, 0,4'b0000,0,0));
    // 4: forwarding: BE with incoming Z=1 while registered Z=0
    vq.push_back(mk(0,1,ADDCC,   4'b0100,1,4'b0001,0,32'h1000,0, 0,4'b0100,1,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,0,4'h0,0,32'h0,   1, 0,4'b0100,0,0));
    vq.push_back(mk(0,1,ADDCC,   4'b0000,0,4'h0,0,32'h0,   0, 0,4'b0000,0,0));
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b0001,0,32'h2000,0, 0,4'b0000,0,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,0,4'h0,0,32'h0,   1, 0,4'b0000,0,0));
    // 9: BA,a annuls slot; slot ADDcc must not write icc
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b1000,1,32'h3000,0, 0,4'b0000,1,1));
    vq.push_back(mk(0,1,ADDCC,   4'b1000,0,4'h0,0,32'h0,   1, 1,4'b0000,0,0));
    // 11: BNE,a untaken annuls; branch in annulled slot is ignored
    vq.push_back(mk(0,1,ADDCC,   4'b0100,0,4'h0,0,32'h0,   0, 0,4'b0100,0,0));
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b1001,1,32'h4000,0, 0,4'b0100,0,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b1000,0,32'h5000,1, 1,4'b0100,0,0));
    // 14: BNE,a taken executes slot
    vq.push_back(mk(0,1,ADDCC,   4'b0000,0,4'h0,0,32'h0,   0, 0,4'b0000,0,0));
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b1001,1,32'h6000,0, 0,4'b0000,1,1));
    vq.push_back(mk(0,1,ADDCC,   4'b1001,0,4'h0,0,32'h0,   1, 0,4'b1001,0,0));
    // 17: condition sweep on icc=1001 via DCTI couples
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b0011,0,32'h7000,0, 0,4'b1001,1,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b1101,0,32'h7100,1, 0,4'b1001,0,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b0100,0,32'h7200,1, 0,4'b1001,1,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b0111,0,32'h7300,1, 0,4'b1001,0,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,0,4'h0,0,32'h0,   1, 0,4'b1001,0,0));
    // 22: ADDXcc forwarded flags 1010 make BGE taken (registered icc would not)
    vq.push_back(mk(0,1,ADDXCC,  4'b1010,1,4'b1011,0,32'h9000,0, 0,4'b1010,1,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,0,4'h0,0,32'h0,   1, 0,4'b1010,0,0));
    // 24: stall holds branch outputs, FSM and icc
    vq.push_back(mk(0,0,NOP,     4'b0000,1,4'b1000,0,32'h8000,0, 0,4'b1010,1,1));
    vq.push_back(mk(1,1,ADDCC,   4'b1111,0,4'h0,0,32'h8000,1, 0,4'b1010,1,1));
    vq.push_back(mk(1,1,ADDCC,   4'b1111,0,4'h0,0,32'h8000,1, 0,4'b1010,1,1));
    vq.push_back(mk(1,1,ADDCC,   4'b1111,0,4'h0,0,32'h8000,1, 0,4'b1010,1,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,0,4'h0,0,32'h0,   0, 0,4'b1010,0,1));
    vq.push_back(mk(0,0,NOP,     4'b0000,0,4'h0,0,32'h0,   1, 0,4'b1010,0,0));
    vq.push_back(mk(1,0,NOP,     4'b0000,1,4'b1000,0,32'hA000,0, 0,4'b1010,0,0));

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset_icc",   -1, 32'(icc),      32'h0);
    chk("reset_taken", -1, 32'(br_taken), 32'h0);
    chk("reset_slot",  -1, 32'(in_slot),  32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      stall = v.stall; alu_valid = v.alu; op3 = v.op3; {n_in, z_in, v_in, c_in} = v.flg;
      br_valid = v.brv; cond = v.cond; a_bit = v.a; br_target_in = v.tgt; instr_valid = v.iv;
      #1;
      chk("annul_slot", i, 32'(annul_slot), 32'(v.e_ann));
      @(posedge clk); #1;
      chk("icc",      i, 32'(icc),      32'(v.e_icc));
      chk("cin",      i, 32'(cin),      32'(v.e_icc[0]));
      chk("br_taken", i, 32'(br_taken), 32'(v.e_tk));
      chk("in_slot",  i, 32'(in_slot),  32'(v.e_slot));
      if (v.e_tk) chk("br_target", i, br_target, v.e_tgt);
    end

    // Reset asserted mid-SLOT with annul pending: immediate return to IDLE, no redirect
    idle_inputs();
    br_valid = 1; cond = 4'b1000; a_bit = 1; br_target_in = 32'hB000;
    @(posedge clk); #1;
    idle_inputs();
    instr_valid = 1;
    #1;
    chk("pre_reset_annul", 100, 32'(annul_slot), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_icc",   101, 32'(icc),        32'h0);
    chk("async_rst_taken", 101, 32'(br_taken),   32'h0);
    chk("async_rst_slot",  101, 32'(in_slot),    32'h0);
    chk("async_rst_annul", 101, 32'(annul_slot), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    instr_valid = 0;
    @(posedge clk); #1;
    chk("post_rst_taken", 102, 32'(br_taken), 32'h0);
    chk("post_rst_slot",  102, 32'(in_slot),  32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
